// File: rtl/audio_tone_seq.sv
// Step-sequenced tone generator: a 16-bit phase accumulator whose increment is set by the
// current sequencer step, shaped into mute/square/sawtooth/triangle samples once per tick.
module audio_tone_seq #(
  parameter int unsigned SAMPLE_DIV = 1024,
  parameter int unsigned STEP_TICKS = 6250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] audio_select,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic [3:0] note_idx
);

  localparam int unsigned DivW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TempoW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [DivW-1:0]   DivMax   = DivW'(SAMPLE_DIV - 1);
  localparam logic [TempoW-1:0] TempoMax = TempoW'(STEP_TICKS - 1);
  localparam logic [7:0]        Silence  = 8'h80;

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [TempoW-1:0] tempo_q, tempo_d;
  logic [15:0]       phase_q, phase_d;
  logic [3:0]        note_q, note_d;
  logic [7:0]        sample_q, sample_d;
  logic              valid_q, valid_d;

  logic        tick;
  logic        rest;
  logic [15:0] inc;
  logic [15:0] phase_next;
  logic [7:0]  wave;

  assign tick       = (state_q == StPlay) && (div_q == DivMax);
  assign rest       = (note_q == 4'hF);
  assign inc        = rest ? 16'h0000 : {4'h0, note_q + 4'd1, 8'h00};
  assign phase_next = phase_q + inc;

  // Waveform is taken from the phase after this tick's increment.
  always_comb begin
    wave = Silence;
    if (!rest) begin
      case (audio_select)
        2'b01:   wave = phase_next[15] ? 8'hFF : 8'h00;
        2'b10:   wave = phase_next[15:8];
        2'b11:   wave = phase_next[15] ? ~phase_next[14:7] : phase_next[14:7];
        default: wave = Silence;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tempo_d  = tempo_q;
    phase_d  = phase_q;
    note_d   = note_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        sample_d = Silence;
        if (enable) begin
          state_d = StPlay;
          div_d   = '0;
          tempo_d = '0;
          phase_d = '0;
          note_d  = '0;
        end
      end
      StPlay: begin
        if (!enable) begin
          state_d  = StIdle;
          sample_d = Silence;
        end
        // A tick in the leaving cycle still completes and overrides the silence load.
        if (tick) begin
          div_d    = '0;
          phase_d  = phase_next;
          sample_d = wave;
          valid_d  = 1'b1;
          if (tempo_q == TempoMax) begin
            tempo_d = '0;
            note_d  = note_q + 4'd1;
          end else begin
            tempo_d = tempo_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      tempo_q  <= '0;
      phase_q  <= '0;
      note_q   <= '0;
      sample_q <= Silence;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tempo_q  <= tempo_d;
      phase_q  <= phase_d;
      note_q   <= note_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign note_idx     = note_q;

endmodule

// File: tb/tb_audio_tone_seq.sv
// Directed bench for audio_tone_seq: a fast instance (DIV=4, STEP=2) and a square-wave
// instance (DIV=2, STEP=1000), with hand-computed expected samples.
module tb_audio_tone_seq;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [1:0] sel;
  logic [7:0] sample;
  logic       sample_valid;
  logic [3:0] note_idx;

  logic       rst2, enable2;
  logic [1:0] sel2;
  logic [7:0] sq_sample;
  logic       sq_valid;
  logic [3:0] sq_note;

  int checks   = 0;
  int failures = 0;

  logic [7:0] saw_tab  [6] = '{8'h01, 8'h02, 8'h04, 8'h06, 8'h09, 8'h0C};
  logic [3:0] note_tab [6] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3};

  always #5 clk = ~clk;

  audio_tone_seq #(.SAMPLE_DIV(4), .STEP_TICKS(2)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .audio_select (sel),
    .sample       (sample),
    .sample_valid (sample_valid),
    .note_idx     (note_idx)
  );

  audio_tone_seq #(.SAMPLE_DIV(2), .STEP_TICKS(1000)) u_dut_sq (
    .clk          (clk),
    .rst          (rst2),
    .enable       (enable2),
    .audio_select (sel2),
    .sample       (sq_sample),
    .sample_valid (sq_valid),
    .note_idx     (sq_note)
  );

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_strobe(output bit got);
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 64) begin
      @(negedge clk);
      got = (sample_valid === 1'b1);
      n++;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b1;
    sel    = 2'b10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (sample !== 8'h80) begin
        failures++; $display("FAIL reset_sample cyc=%0d got=%h want=80", i, sample);
      end
      checks++;
      if (sample_valid !== 1'b0) begin
        failures++; $display("FAIL reset_valid cyc=%0d got=%b want=0", i, sample_valid);
      end
      checks++;
      if (note_idx !== 4'd0) begin
        failures++; $display("FAIL reset_note cyc=%0d got=%0d want=0", i, note_idx);
      end
    end
    rst    = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (sample !== 8'h80 || sample_valid !== 1'b0) begin
      failures++; $display("FAIL reset_idle got=%h/%b want=80/0", sample, sample_valid);
    end
  endtask

  task automatic test_sawtooth();
    logic       exp_v;
    logic [7:0] exp_s;
    logic [3:0] exp_n;
    do_reset();
    sel    = 2'b10;
    enable = 1'b1;
    exp_s  = 8'h80;
    exp_n  = 4'd0;
    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      exp_v = (i >= 4) && (i % 4 == 0);
      if (exp_v) begin
        exp_s = saw_tab[i/4-1];
        exp_n = note_tab[i/4-1];
      end
      checks++;
      if (sample_valid !== exp_v) begin
        failures++; $display("FAIL saw_valid cyc=%0d got=%b want=%b", i, sample_valid, exp_v);
      end
      checks++;
      if (sample !== exp_s) begin
        failures++; $display("FAIL saw_sample cyc=%0d got=%h want=%h", i, sample, exp_s);
      end
      checks++;
      if (note_idx !== exp_n) begin
        failures++; $display("FAIL saw_note cyc=%0d got=%0d want=%0d", i, note_idx, exp_n);
      end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rest_wrap();
    bit         got;
    int         timeouts;
    logic [1:0] sel_tab  [5] = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b10};
    logic [7:0] samp_tab [5] = '{8'h80, 8'h80, 8'h1D, 8'hFF, 8'hF4};
    logic [3:0] nt_tab   [5] = '{4'd15, 4'd0, 4'd0, 4'd1, 4'd1};
    do_reset();
    sel      = 2'b10;
    enable   = 1'b1;
    timeouts = 0;
    for (int k = 0; k < 30; k++) begin
      wait_strobe(got);
      if (!got) timeouts++;
    end
    checks++;
    if (timeouts != 0) begin
      failures++; $display("FAIL rest_run_strobes got=%0d timeouts want=0", timeouts);
    end
    checks++;
    if (note_idx !== 4'd15 || sample !== 8'hF0) begin
      failures++; $display("FAIL rest_entry got=%0d/%h want=15/f0", note_idx, sample);
    end
    for (int k = 0; k < 5; k++) begin
      sel = sel_tab[k];
      wait_strobe(got);
      checks++;
      if (!got || sample !== samp_tab[k]) begin
        failures++;
        $display("FAIL rest_sample k=%0d got=%h want=%h", k, sample, samp_tab[k]);
      end
      checks++;
      if (note_idx !== nt_tab[k]) begin
        failures++; $display("FAIL rest_note k=%0d got=%0d want=%0d", k, note_idx, nt_tab[k]);
      end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_select_timing();
    bit got;
    do_reset();
    sel    = 2'b10;
    enable = 1'b1;
    wait_strobe(got);
    checks++;
    if (!got || sample !== 8'h01) begin
      failures++; $display("FAIL sel_first got=%h want=01", sample);
    end
    for (int i = 0; i < 3; i++) begin
      sel = (i == 0) ? 2'b11 : ((i == 1) ? 2'b10 : 2'b01);
      @(negedge clk);
      checks++;
      if (sample_valid !== 1'b0 || sample !== 8'h01) begin
        failures++; $display("FAIL sel_hold i=%0d got=%h/%b want=01/0", i, sample, sample_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'h00) begin
      failures++; $display("FAIL sel_square got=%h/%b want=00/1", sample, sample_valid);
    end
    sel = 2'b10;
    @(negedge clk);
    @(negedge clk);
    sel = 2'b11;
    @(negedge clk);
    checks++;
    if (sample !== 8'h00) begin
      failures++; $display("FAIL sel_hold2 got=%h want=00", sample);
    end
    @(negedge clk);
    checks++;
    if (sample_valid !== 1'b1 || sample !== 8'h08) begin
      failures++; $display("FAIL sel_triangle got=%h/%b want=08/1", sample, sample_valid);
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mute();
    bit got;
    do_reset();
    sel    = 2'b00;
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_strobe(got);
      checks++;
      if (!got || sample !== 8'h80) begin
        failures++; $display("FAIL mute_sample k=%0d got=%h/%b want=80/1", k, sample, got);
      end
      checks++;
      if (note_idx !== 4'(k)) begin
        failures++; $display("FAIL mute_note k=%0d got=%0d want=%0d", k, note_idx, k);
      end
      @(negedge clk);
      checks++;
      if (sample_valid !== 1'b0) begin
        failures++; $display("FAIL mute_strobe_len k=%0d got=%b want=0", k, sample_valid);
      end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_square();
    int         n, cycles;
    logic [7:0] s127, s128, s255, s256;
    s127 = 8'h55; s128 = 8'h55; s255 = 8'h55; s256 = 8'h55;
    rst2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst2    = 1'b0;
    sel2    = 2'b01;
    enable2 = 1'b1;
    n       = 0;
    cycles  = 0;
    while (n < 256 && cycles < 1200) begin
      @(negedge clk);
      cycles++;
      if (sq_valid === 1'b1) begin
        n++;
        if (n == 127) s127 = sq_sample;
        if (n == 128) s128 = sq_sample;
        if (n == 255) s255 = sq_sample;
        if (n == 256) s256 = sq_sample;
      end
    end
    checks++;
    if (n != 256) begin
      failures++; $display("FAIL sq_tick_count got=%0d want=256", n);
    end
    checks++;
    if (s127 !== 8'h00) begin
      failures++; $display("FAIL sq_tick127 got=%h want=00", s127);
    end
    checks++;
    if (s128 !== 8'hFF) begin
      failures++; $display("FAIL sq_tick128 got=%h want=ff", s128);
    end
    checks++;
    if (s255 !== 8'hFF) begin
      failures++; $display("FAIL sq_tick255 got=%h want=ff", s255);
    end
    checks++;
    if (s256 !== 8'h00 || sq_note !== 4'd0) begin
      failures++; $display("FAIL sq_wrap got=%h/%0d want=00/0", s256, sq_note);
    end
    enable2 = 1'b0;
  endtask

  task automatic test_disable_reenable();
    bit         got;
    logic       exp_v;
    logic [7:0] exp_s;
    logic [3:0] exp_n;
    do_reset();
    sel    = 2'b10;
    enable = 1'b1;
    wait_strobe(got);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (sample !== 8'h80 || sample_valid !== 1'b0 || note_idx !== 4'd0) begin
        failures++;
        $display("FAIL dis_idle i=%0d got=%h/%b/%0d want=80/0/0", i, sample, sample_valid,
                 note_idx);
      end
    end
    enable = 1'b1;
    exp_s  = 8'h80;
    exp_n  = 4'd0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      exp_v = (i >= 4) && (i % 4 == 0);
      if (exp_v) begin
        exp_s = saw_tab[i/4-1];
        exp_n = note_tab[i/4-1];
      end
      checks++;
      if (sample_valid !== exp_v || sample !== exp_s || note_idx !== exp_n) begin
        failures++;
        $display("FAIL reen_seq cyc=%0d got=%h/%b/%0d want=%h/%b/%0d", i, sample, sample_valid,
                 note_idx, exp_s, exp_v, exp_n);
      end
      if (i == 15) enable = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (sample !== 8'h80 || sample_valid !== 1'b0 || note_idx !== 4'd2) begin
      failures++;
      $display("FAIL tick_disable got=%h/%b/%0d want=80/0/2", sample, sample_valid, note_idx);
    end
  endtask

  task automatic test_reset_in_tick();
    bit got;
    do_reset();
    sel    = 2'b10;
    enable = 1'b1;
    wait_strobe(got);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (sample !== 8'h80 || sample_valid !== 1'b0 || note_idx !== 4'd0) begin
      failures++;
      $display("FAIL rst_tick got=%h/%b/%0d want=80/0/0", sample, sample_valid, note_idx);
    end
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (sample_valid !== (i == 4) || sample !== ((i == 4) ? 8'h01 : 8'h80)) begin
        failures++;
        $display("FAIL rst_restart cyc=%0d got=%h/%b want=%h/%b", i, sample, sample_valid,
                 (i == 4) ? 8'h01 : 8'h80, (i == 4));
      end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    sel     = 2'b00;
    rst2    = 1'b1;
    enable2 = 1'b0;
    sel2    = 2'b00;
    test_reset();
    test_sawtooth();
    test_rest_wrap();
    test_select_timing();
    test_mute();
    test_square();
    test_disable_reenable();
    test_reset_in_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
